seq_multiplier_nbit: RTL

//   Parametrised sequential shift-add multiplier; successor to the fixed-width combinational multipliers.

---
 rtl/seq_multiplier_nbit_if.sv | 25 ++
 rtl/seq_multiplier_nbit.sv | 96 +++++++++
 2 files changed

// File: rtl/seq_multiplier_nbit_if.sv
// Operand/product handshake bundle for seq_multiplier_nbit.
// master drives operands and out_ready; slave is the multiplier.
interface seq_multiplier_nbit_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_multiplier_nbit.sv
// Shift-add multiplier, unsigned or two's-complement per transaction.
// Latency: out_valid high the cycle after accept edge + WIDTH edges.
// Backpressure: product held in DONE until out_ready; no accept outside IDLE.
module seq_multiplier_nbit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_multiplier_nbit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   p_r;
    logic [WIDTH:0]       sum;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 last;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Most-negative input's magnitude still fits as unsigned WIDTH bits.
    assign a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    assign last  = (cnt == CW'(WIDTH-1));

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CALC;
            CALC:    if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p_r    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        p_r <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.p         = p_r;
endmodule
